fifo_read_arbiter: RTL and testbench

FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

---
 rtl/fifo_read_arbiter.sv | 54 +++++
 tb/tb_fifo_read_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: shares one prefetch FIFO read port among three decode clients
// using fixed-priority ownership with direct handoff, flush abort and a saturating byte count.
module fifo_read_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    input  logic [2:0] client_rd_en,
    output logic [2:0] client_empty,
    output logic [2:0] grant,
    output logic       fifo_rd_en,
    input  logic       fifo_empty,
    input  logic       flush,
    output logic       busy,
    output logic [3:0] bytes_read
);
    typedef enum logic {IDLE, OWNED} state_e;
    state_e     state_q, state_d;
    logic [2:0] grant_q, grant_d, cand, pick;
    logic [3:0] bytes_q, bytes_d, bytes_inc;
    assign fifo_rd_en   = |(client_rd_en & grant_q) & ~fifo_empty & ~flush;
    assign bytes_inc    = (fifo_rd_en && bytes_q != 4'd15) ? bytes_q + 4'd1 : bytes_q;
    // the releasing owner is masked so a handoff always goes to someone else
    assign cand         = (state_q == OWNED) ? req & ~grant_q : req;
    assign pick         = cand & (~cand + 3'd1);
    assign grant        = grant_q;
    assign busy         = |grant_q;
    assign bytes_read   = bytes_q;
    assign client_empty = ~grant_q | {3{fifo_empty}};
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        bytes_d = bytes_inc;
        if (flush) begin
            state_d = IDLE;
            grant_d = '0;
            bytes_d = '0;
        end else if (state_q == IDLE || !(|(req & grant_q))) begin
            state_d = (|cand) ? OWNED : IDLE;
            grant_d = pick;
            bytes_d = (|cand) ? 4'd0 : bytes_inc;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            bytes_q <= bytes_d;
        end
    end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: directed stimulus checked every cycle against an owner/byte-count
// model, plus literal expectations for the key scenarios.
module tb_fifo_read_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] req, client_rd_en, client_empty, grant;
    logic       fifo_rd_en, fifo_empty, flush, busy;
    logic [3:0] bytes_read;
    int n_chk = 0, n_fail = 0, pulses = 0, p0;
    int m_owner = -1, m_bytes = 0, m_nxt;
    bit m_rdv;
    logic [7:0] vec [10] = '{
        {3'b011, 3'b011, 1'b0, 1'b0}, {3'b010, 3'b111, 1'b0, 1'b0},
        {3'b100, 3'b100, 1'b0, 1'b0}, {3'b101, 3'b101, 1'b1, 1'b0},
        {3'b001, 3'b001, 1'b0, 1'b0}, {3'b000, 3'b001, 1'b0, 1'b0},
        {3'b000, 3'b000, 1'b0, 1'b0}, {3'b110, 3'b010, 1'b0, 1'b1},
        {3'b110, 3'b010, 1'b0, 1'b0}, {3'b000, 3'b000, 1'b0, 1'b0}};

    fifo_read_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .client_rd_en(client_rd_en),
        .client_empty(client_empty), .grant(grant), .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty), .flush(flush), .busy(busy), .bytes_read(bytes_read));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_rd();
        return m_owner >= 0 && client_rd_en[m_owner] && !fifo_empty && !flush;
    endfunction

    // model: owner index (-1 = none) and byte count, from the arbitration rules
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1;
            m_bytes = 0;
        end else begin
            m_rdv = m_rd();
            m_nxt = -1;
            if (!flush) begin
                if (m_owner >= 0 && req[m_owner]) m_nxt = m_owner;
                else for (int i = 0; i < 3; i++) if (m_nxt < 0 && req[i] && i != m_owner) m_nxt = i;
            end
            if (flush || (m_nxt >= 0 && m_nxt != m_owner)) m_bytes = 0;
            else if (m_rdv && m_bytes < 15) m_bytes++;
            m_owner = m_nxt;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) pulses++;
        chk("grant", grant, m_owner < 0 ? 0 : (1 << m_owner));
        chk("busy", busy, m_owner >= 0);
        chk("fifo_rd_en", fifo_rd_en, m_rd());
        chk("client_empty", client_empty, m_owner < 0 ? 7 : (fifo_empty ? 7 : 7 & ~(1 << m_owner)));
        chk("bytes_read", bytes_read, m_bytes);
    end

    initial begin
        reset_n = 1'b0; req = '0; client_rd_en = '0; fifo_empty = 1'b1; flush = 1'b0;
        repeat (2) tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bytes", bytes_read, 0);
        chk("rst_cempty", client_empty, 7);
        reset_n = 1'b1;
        fifo_empty = 1'b0; req = 3'b010;
        tick();
        chk("s1_grant", grant, 2);
        client_rd_en = 3'b010; p0 = pulses;
        repeat (3) tick();
        chk("s1_pulses", pulses - p0, 3);
        chk("s1_bytes", bytes_read, 3);
        client_rd_en = '0; req = '0;
        tick();
        chk("s1_release", grant, 0);
        chk("s1_hold", bytes_read, 3);
        req = 3'b111;
        tick();
        chk("s2_grant", grant, 1);
        client_rd_en = 3'b001;
        tick();
        chk("s2_bytes1", bytes_read, 1);
        client_rd_en = '0; req = 3'b110;
        tick();
        chk("s2_handoff", grant, 2);
        chk("s2_busy", busy, 1);
        chk("s2_clear", bytes_read, 0);
        req = '0;
        tick();
        req = 3'b010;
        tick();
        fifo_empty = 1'b1; client_rd_en = 3'b111;
        #1;
        chk("s3_rd_empty", fifo_rd_en, 0);
        chk("s3_ce_empty", client_empty, 7);
        tick();
        fifo_empty = 1'b0;
        #1;
        chk("s3_ce", client_empty, 5);
        chk("s3_rd", fifo_rd_en, 1);
        p0 = pulses;
        repeat (2) tick();
        chk("s3_pulses", pulses - p0, 2);
        chk("s3_bytes", bytes_read, 2);
        client_rd_en = '0; req = '0;
        tick();
        req = 3'b001;
        tick();
        client_rd_en = 3'b001;
        repeat (17) tick();
        chk("s4_sat", bytes_read, 15);
        client_rd_en = '0; req = '0;
        tick();
        chk("s4_release", grant, 0);
        chk("s4_hold", bytes_read, 15);
        req = 3'b100;
        tick();
        chk("s5_clear", bytes_read, 0);
        client_rd_en = 3'b100;
        repeat (2) tick();
        chk("s5_bytes", bytes_read, 2);
        flush = 1'b1;
        #1;
        chk("s5_flush_rd", fifo_rd_en, 0);
        tick();
        chk("s5_flush_grant", grant, 0);
        chk("s5_flush_bytes", bytes_read, 0);
        tick();
        chk("s5_no_grant", grant, 0);
        flush = 1'b0;
        tick();
        chk("s5_regrant", grant, 4);
        #2;
        chk("s6_rd_before", fifo_rd_en, 1);
        reset_n = 1'b0;
        #1;
        chk("s6_grant", grant, 0);
        chk("s6_busy", busy, 0);
        chk("s6_rd", fifo_rd_en, 0);
        chk("s6_ce", client_empty, 7);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("s6_after", grant, 4);
        chk("s6_bytes", bytes_read, 0);
        for (int i = 0; i < 10; i++) begin
            {req, client_rd_en, fifo_empty, flush} = vec[i];
            tick();
        end
        req = '0; client_rd_en = '0; flush = 1'b0;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
